onchip_ram_dp: RTL and testbench
================================

Name: onchip_ram_dp

Overview:
- Parametrised, true-dual-port on-chip RAM with two independent Avalon-MM slave ports, s1 and s2.
- Successor to the fixed 32x1024 single-port on-chip memory. Adds generic width and depth, selectable read latency of 1 or 2, `readdatavalid`/`waitrequest` handshakes, and defined collision rules.
- Sits on the system interconnect as program/data memory; s2 typically serves a DMA or a second master.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 10, word address width; DEPTH = 2**ADDR_W.
- READ_LATENCY, 1, cycles from accepted read to data; legal values 1 or 2.
- INIT_FILE, "onchip_ram_dp.hex", memory init file; empty string means no init.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- reset_req  in  1  reset-request; stalls the block like clken=0
- clken  in  1  global clock enable
- s1_address  in  ADDR_W  word address
- s1_chipselect  in  1  port select
- s1_read  in  1  read strobe
- s1_write  in  1  write strobe
- s1_byteenable  in  DATA_W/8  byte lanes
- s1_writedata  in  DATA_W  write data
- s1_readdata  out  DATA_W  read data
- s1_readdatavalid  out  1  read data valid
- s1_waitrequest  out  1  stall
- s2_*  same set as s1, identical widths and meanings
- init_done  out  1  memory ready for access

Behaviour:
- Handshakes and stalls
  - `en = clken & ~reset_req`.
  - A port request is accepted when `chipselect & (read|write) & ~waitrequest`.
  - `waitrequest = ~en | ~init_done`.
  - When `en` = 0, nothing advances: the memory array, read pipeline and clear FSM all hold.
- Reset values
  - `readdata` = 0, `readdatavalid` = 0, pipeline flushed.
  - Array contents are not reset.
- Writes
  - Writes take effect at the clock edge of acceptance.
  - Only lanes whose `byteenable` bit is set are written; `byteenable` = 0 leaves the word unchanged.
- Reads
  - An accepted read asserts `readdatavalid` for exactly one cycle, exactly READ_LATENCY enabled cycles later.
  - Back-to-back reads are fully pipelined: one per cycle per port.
  - `readdata` holds its last value when not valid.
- Read and write in the same cycle on one port: the write is performed; the read is ignored and no `readdatavalid` is generated.
- Same-port read-during-write: not possible; single request per cycle.
- Mixed-port read-during-write to the same address: the reader gets OLD data.
- Double write to the same address in one cycle: merged per byte.
  - A lane enabled on both ports takes s1 data.
  - A lane enabled only on s2 takes s2 data.
- Address width: addresses are exactly ADDR_W bits, with no wrap or aliasing logic.
- Reset mid-read: in-flight reads are discarded; no `readdatavalid` appears after reset.
- Without the optional feature, `init_done` = 1 constantly.

Optional Feature:
- Macro: ONCHIP_RAM_CLEAR_EN.
- When defined, a clear FSM runs after reset.
  - States: CLEAR, DONE.
  - Reset forces CLEAR with the address counter at 0 and `init_done` = 0.
  - Each enabled cycle writes all-zero to the counter address with all lanes set, then increments the counter.
  - After writing DEPTH-1, the FSM moves to DONE and sets `init_done` = 1.
  - Clear takes DEPTH enabled cycles; both ports see `waitrequest` = 1 throughout.
  - A reset during CLEAR restarts the clear from address 0.
- When undefined: no FSM is built, INIT_FILE contents are visible immediately, and `init_done` = 1.

Decomposition:
- Package onchip_ram_pkg holds:
  - the READ_LATENCY legality check function;
  - the byte-merge function for the same-cycle, same-address write rule;
  - the clear FSM state enum.
- Sub-module onchip_ram_rd_pipe, instantiated once per port: a `readdatavalid`/`readdata` delay line of depth READ_LATENCY with enable.

Test Plan:
- Reset, then s1 writes 0xDEADBEEF to address 5 with `byteenable` 0xF. s1 then reads address 5 with READ_LATENCY=2 → `s1_readdatavalid` high exactly 2 cycles later, `readdata` 0xDEADBEEF.
- From 0x00000000 at address 7, write 0xAABBCCDD with `byteenable` 0x5 → readback 0x00BB00DD.
- Same cycle: s1 writes 0x11111111 with `byteenable` 0x3 and s2 writes 0x22222222 with `byteenable` 0xE, both to address 9 → readback 0x22221111.
- s2 reads address 3 (holding 0x1) while s1 writes 0x2 to address 3 in the same cycle → s2 gets 0x1; a subsequent read gets 0x2.
- Issue 4 back-to-back reads, deasserting `clken` for 2 cycles mid-stream → 4 valids in order with no loss or duplication; `waitrequest` high only while `clken` = 0.
- With ONCHIP_RAM_CLEAR_EN, ADDR_W=4: after reset, `init_done` rises after 16 cycles and all words read 0. Asserting reset at cycle 8 restarts the clear, giving 16 more cycles.

Source files
------------

// File: rtl/onchip_ram_pkg.sv
// Shared types and helpers for the dual-port on-chip RAM: latency check, byte merge, clear FSM states.
package onchip_ram_pkg;

  localparam int LANE_W = 8;

  typedef enum logic {
    CLR_CLEAR = 1'b0,
    CLR_DONE  = 1'b1
  } clr_state_t;

  function automatic bit read_latency_ok(input int latency);
    return (latency == 1) || (latency == 2);
  endfunction

  // Same-cycle, same-address writes: the lane is written if either port enables it.
  function automatic logic merge_be(input logic be_a, input logic be_b);
    return be_a | be_b;
  endfunction

  // Port A (s1) owns any lane it enables; otherwise the lane takes port B (s2) data.
  function automatic logic [LANE_W-1:0] merge_lane(
    input logic              be_a,
    input logic [LANE_W-1:0] data_a,
    input logic [LANE_W-1:0] data_b
  );
    return be_a ? data_a : data_b;
  endfunction

endpackage

// File: rtl/onchip_ram_rd_pipe.sv
// Per-port readdatavalid/readdata delay line; rd_data is the registered RAM output one cycle after rd_req.
module onchip_ram_rd_pipe #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              rd_req,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);

  logic [LATENCY-1:0] vld_reg;

  if (LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_reg <= '0;
      end else if (en) begin
        vld_reg <= rd_req;
      end
    end
    assign readdata = rd_data;
  end else begin : g_lat2
    logic [DATA_W-1:0] data_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_reg  <= '0;
        data_reg <= '0;
      end else if (en) begin
        vld_reg <= {vld_reg[LATENCY-2:0], rd_req};
        if (vld_reg[0]) begin
          data_reg <= rd_data;
        end
      end
    end
    assign readdata = data_reg;
  end

  // A stalled pipeline holds its slot; masking with en keeps each valid to a single observed beat.
  assign readdatavalid = vld_reg[LATENCY-1] & en;

endmodule

// File: rtl/onchip_ram_dp.sv
// True-dual-port Avalon-MM on-chip RAM with byte enables, 1- or 2-cycle read latency.
// Define ONCHIP_RAM_CLEAR_EN to zero the whole array after reset before any access is accepted.
module onchip_ram_dp
  import onchip_ram_pkg::*;
#(
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 10,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "onchip_ram_dp.hex"
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reset_req,
  input  logic                     clken,
  input  logic [ADDR_W-1:0]        s1_address,
  input  logic                     s1_chipselect,
  input  logic                     s1_read,
  input  logic                     s1_write,
  input  logic [DATA_W/8-1:0]      s1_byteenable,
  input  logic [DATA_W-1:0]        s1_writedata,
  output logic [DATA_W-1:0]        s1_readdata,
  output logic                     s1_readdatavalid,
  output logic                     s1_waitrequest,
  input  logic [ADDR_W-1:0]        s2_address,
  input  logic                     s2_chipselect,
  input  logic                     s2_read,
  input  logic                     s2_write,
  input  logic [DATA_W/8-1:0]      s2_byteenable,
  input  logic [DATA_W-1:0]        s2_writedata,
  output logic [DATA_W-1:0]        s2_readdata,
  output logic                     s2_readdatavalid,
  output logic                     s2_waitrequest,
  output logic                     init_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / LANE_W;

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("onchip_ram_dp: READ_LATENCY must be 1 or 2");
  end

  logic                             en;
  logic [1:0]                       cs;
  logic [1:0]                       rd;
  logic [1:0]                       wr;
  logic [1:0]                       wait_w;
  logic [1:0]                       acc_rd;
  logic [1:0]                       acc_wr;
  logic [1:0][ADDR_W-1:0]           addr;
  logic [1:0][NB-1:0]               be;
  logic [1:0][NB-1:0][LANE_W-1:0]   wdata;
  logic [1:0][DATA_W-1:0]           rdata;
  logic [1:0]                       rvalid;
  logic                             same_wr;
  logic [NB-1:0]                    m_be;
  logic [NB-1:0][LANE_W-1:0]        m_data;
  logic                             clr_we;
  logic [ADDR_W-1:0]                clr_addr;

  logic [NB-1:0][LANE_W-1:0] mem [DEPTH];

  assign en = clken & ~reset_req;

  assign cs       = {s2_chipselect, s1_chipselect};
  assign rd       = {s2_read, s1_read};
  assign wr       = {s2_write, s1_write};
  assign addr[0]  = s1_address;
  assign addr[1]  = s2_address;
  assign be[0]    = s1_byteenable;
  assign be[1]    = s2_byteenable;
  assign wdata[0] = s1_writedata;
  assign wdata[1] = s2_writedata;
  assign wait_w   = {2{~en | ~init_done}};

  assign s1_waitrequest   = wait_w[0];
  assign s2_waitrequest   = wait_w[1];
  assign s1_readdata      = rdata[0];
  assign s2_readdata      = rdata[1];
  assign s1_readdatavalid = rvalid[0];
  assign s2_readdatavalid = rvalid[1];

  // Read and write together on one port: the write wins and the read is dropped.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [DATA_W-1:0] q_reg;

    assign acc_wr[gi] = cs[gi] & wr[gi] & ~wait_w[gi];
    assign acc_rd[gi] = cs[gi] & rd[gi] & ~wr[gi] & ~wait_w[gi];

    always_ff @(posedge clk) begin
      if (reset) begin
        q_reg <= '0;
      end else if (acc_rd[gi]) begin
        q_reg <= mem[addr[gi]];
      end
    end

    onchip_ram_rd_pipe #(
      .DATA_W  (DATA_W),
      .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .rd_req        (acc_rd[gi]),
      .rd_data       (q_reg),
      .readdata      (rdata[gi]),
      .readdatavalid (rvalid[gi])
    );
  end

  // Colliding writes collapse onto the s1 path with merged lanes; s2 is then suppressed.
  assign same_wr = acc_wr[0] & acc_wr[1] & (addr[0] == addr[1]);

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign m_be[gi]   = same_wr ? merge_be(be[0][gi], be[1][gi]) : be[0][gi];
    assign m_data[gi] = same_wr ? merge_lane(be[0][gi], wdata[0][gi], wdata[1][gi])
                                : wdata[0][gi];
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end
    for (int b = 0; b < NB; b++) begin
      if (acc_wr[1] && !same_wr && be[1][b]) begin
        mem[addr[1]][b] <= wdata[1][b];
      end
      if (acc_wr[0] && m_be[b]) begin
        mem[addr[0]][b] <= m_data[b];
      end
    end
  end

`ifdef ONCHIP_RAM_CLEAR_EN
  clr_state_t        clr_state_reg;
  logic [ADDR_W-1:0] clr_addr_reg;
  logic              init_done_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_state_reg <= CLR_CLEAR;
      clr_addr_reg  <= '0;
      init_done_reg <= 1'b0;
    end else if (en) begin
      case (clr_state_reg)
        CLR_CLEAR: begin
          clr_addr_reg <= clr_addr_reg + 1'b1;
          if (&clr_addr_reg) begin
            clr_state_reg <= CLR_DONE;
            init_done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign clr_we    = en & (clr_state_reg == CLR_CLEAR);
  assign clr_addr  = clr_addr_reg;
  assign init_done = init_done_reg;
`else
  assign clr_we    = 1'b0;
  assign clr_addr  = '0;
  assign init_done = 1'b1;
`endif

endmodule

// File: tb/tb_onchip_ram_dp.sv
// Directed, scoreboarded bench for onchip_ram_dp (ADDR_W=4, READ_LATENCY=2); honours ONCHIP_RAM_CLEAR_EN.
module tb_onchip_ram_dp;

  localparam int LAT = 2;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              reset_req;
  logic              clken;
  logic [1:0]        cs;
  logic [1:0]        rd;
  logic [1:0]        wr;
  logic [1:0][3:0]   addr;
  logic [1:0][3:0]   be;
  logic [1:0][31:0]  wdata;
  wire  [1:0][31:0]  rdata;
  wire  [1:0]        rvalid;
  wire  [1:0]        wreq;
  wire               init_done;

  exp_t        sb_q [2][$];
  logic [31:0] pend_exp [2];
  int          en_cyc;
  int          assert_cnt;
  int          fail_cnt;
  bit          mon_en;

`ifdef ONCHIP_RAM_CLEAR_EN
  localparam logic INIT_AT_RESET = 1'b0;
`else
  localparam logic INIT_AT_RESET = 1'b1;
`endif

  onchip_ram_dp #(
    .DATA_W       (32),
    .ADDR_W       (4),
    .READ_LATENCY (LAT),
    .INIT_FILE    ("")
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .reset_req        (reset_req),
    .clken            (clken),
    .s1_address       (addr[0]),
    .s1_chipselect    (cs[0]),
    .s1_read          (rd[0]),
    .s1_write         (wr[0]),
    .s1_byteenable    (be[0]),
    .s1_writedata     (wdata[0]),
    .s1_readdata      (rdata[0]),
    .s1_readdatavalid (rvalid[0]),
    .s1_waitrequest   (wreq[0]),
    .s2_address       (addr[1]),
    .s2_chipselect    (cs[1]),
    .s2_read          (rd[1]),
    .s2_write         (wr[1]),
    .s2_byteenable    (be[1]),
    .s2_writedata     (wdata[1]),
    .s2_readdata      (rdata[1]),
    .s2_readdatavalid (rvalid[1]),
    .s2_waitrequest   (wreq[1]),
    .init_done        (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clken && !reset_req) en_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Every enabled negedge: valid must appear exactly when the head entry falls due.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int p = 0; p < 2; p++) begin
        bit exp_v;
        exp_v = (sb_q[p].size() > 0) && (sb_q[p][0].due == en_cyc) && clken && !reset_req;
        check($sformatf("s%0d_readdatavalid", p + 1), {31'b0, rvalid[p]}, {31'b0, exp_v});
        if (exp_v) begin
          if (rvalid[p]) begin
            check($sformatf("s%0d_readdata", p + 1), rdata[p], sb_q[p][0].data);
            $display("s%0d read  data=0x%08h due=%0d", p + 1, rdata[p], sb_q[p][0].due);
          end
          void'(sb_q[p].pop_front());
        end
      end
    end
  end

  task automatic set_wr(input int p, input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    cs[p] = 1'b1; wr[p] = 1'b1; addr[p] = a; wdata[p] = d; be[p] = b;
    $display("s%0d write addr=%0d data=0x%08h be=0x%0h", p + 1, a, d, b);
  endtask

  task automatic set_rd(input int p, input logic [3:0] a, input logic [31:0] e);
    cs[p] = 1'b1; rd[p] = 1'b1; addr[p] = a; pend_exp[p] = e;
  endtask

  // One request beat, optionally preceded by a stall via clken (use_req=0) or reset_req (use_req=1).
  task automatic step(input int stall_n, input bit use_req);
    if (stall_n > 0) begin
      if (use_req) reset_req = 1'b1;
      else clken = 1'b0;
      repeat (stall_n) begin
        @(negedge clk);
        check("s1_waitrequest_stall", {31'b0, wreq[0]}, 32'd1);
        check("s2_waitrequest_stall", {31'b0, wreq[1]}, 32'd1);
        @(posedge clk); #1;
      end
      clken = 1'b1;
      reset_req = 1'b0;
    end
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      if (cs[p]) begin
        check($sformatf("s%0d_waitrequest_run", p + 1), {31'b0, wreq[p]}, 32'd0);
        if (rd[p] && !wr[p]) sb_q[p].push_back('{data: pend_exp[p], due: en_cyc + LAT});
      end
    end
    @(posedge clk); #1;
    cs = '0; rd = '0; wr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int hold, input bit measure);
    int cnt;
    bit wr_ok;
    reset = 1'b1;
    sb_q[0].delete();
    sb_q[1].delete();
    repeat (hold) @(posedge clk);
    @(negedge clk);
    check("s1_readdata_reset", rdata[0], 32'h0);
    check("s2_readdata_reset", rdata[1], 32'h0);
    check("s1_valid_reset", {31'b0, rvalid[0]}, 32'd0);
    check("s2_valid_reset", {31'b0, rvalid[1]}, 32'd0);
    check("init_done_reset", {31'b0, init_done}, {31'b0, INIT_AT_RESET});
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset released (hold=%0d)", hold);
    if (measure) begin
`ifdef ONCHIP_RAM_CLEAR_EN
      cnt = 0;
      wr_ok = 1'b1;
      while (!init_done && cnt < 100) begin
        if (!(wreq[0] && wreq[1])) wr_ok = 1'b0;
        @(posedge clk); #1;
        cnt++;
      end
      check("clear_cycles", cnt, 32'd16);
      check("clear_waitrequest", {31'b0, wr_ok}, 32'd1);
`else
      cnt = 0;
      wr_ok = 1'b1;
      check("init_done_run", {31'b0, init_done}, 32'd1);
`endif
    end
  endtask

  initial begin
    reset = 1'b0; reset_req = 1'b0; clken = 1'b1;
    cs = '0; rd = '0; wr = '0; addr = '0; be = '0; wdata = '0;
    pend_exp[0] = '0; pend_exp[1] = '0;
    en_cyc = 0; assert_cnt = 0; fail_cnt = 0; mon_en = 1'b0;
    #1;
    do_reset(3, 1'b1);
    mon_en = 1'b1;

    // Basic write then read, 2-cycle latency
    set_wr(0, 4'd5, 32'hDEADBEEF, 4'hF); step(0, 0);
    set_rd(0, 4'd5, 32'hDEADBEEF);       step(0, 0);
    idle(4);

    // Partial byte write
    set_wr(0, 4'd7, 32'h00000000, 4'hF); step(0, 0);
    set_wr(0, 4'd7, 32'hAABBCCDD, 4'h5); step(0, 0);
    set_rd(0, 4'd7, 32'h00BB00DD);       step(0, 0);
    idle(4);

    // Same-cycle double write merged per lane
    set_wr(0, 4'd9, 32'h11111111, 4'h3);
    set_wr(1, 4'd9, 32'h22222222, 4'hE); step(0, 0);
    set_rd(1, 4'd9, 32'h22221111);       step(0, 0);
    idle(4);

    // Mixed-port read-during-write returns old data
    set_wr(0, 4'd3, 32'h00000001, 4'hF); step(0, 0);
    set_rd(1, 4'd3, 32'h00000001);
    set_wr(0, 4'd3, 32'h00000002, 4'hF); step(0, 0);
    set_rd(1, 4'd3, 32'h00000002);       step(0, 0);
    idle(4);

    // Read with write on one port: write lands, no valid
    set_wr(0, 4'd7, 32'h12345678, 4'hF);
    rd[0] = 1'b1;                        step(0, 0);
    idle(4);
    set_rd(0, 4'd7, 32'h12345678);       step(0, 0);
    idle(4);

    // Back-to-back stream with clken and reset_req stalls mid-flight
    set_rd(0, 4'd5, 32'hDEADBEEF);       step(0, 0);
    set_rd(0, 4'd7, 32'h12345678);       step(0, 0);
    set_rd(0, 4'd9, 32'h22221111);       step(2, 0);
    set_rd(0, 4'd3, 32'h00000002);       step(1, 1);
    idle(6);

    // Reset with a read in flight: nothing may come out
    set_rd(0, 4'd5, 32'hDEADBEEF);       step(0, 0);
    do_reset(2, 1'b1);
    idle(6);

`ifdef ONCHIP_RAM_CLEAR_EN
    for (int a = 0; a < 16; a++) begin
      set_rd(1, a[3:0], 32'h0);          step(0, 0);
    end
    idle(6);
    do_reset(2, 1'b0);
    idle(8);
    check("init_done_mid_clear", {31'b0, init_done}, 32'd0);
    do_reset(1, 1'b1);
    idle(2);
`endif

    check("s1_scoreboard_drained", sb_q[0].size(), 32'd0);
    check("s2_scoreboard_drained", sb_q[1].size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
